instr_loader: RTL
=================

Name: instr_loader

Overview:
- Writer-side counterpart to the instruction memory that the CPU fetches from.
- Accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instruction words.
- Writes each word into instruction memory at consecutive byte addresses starting at 0.
- Holds the CPU in reset until the load completes; releases it only on a clean finish.

Parameters:
- ADDRESS_WIDTH, 16, width of the words_loaded counter's address space; the word index is bounded by this.
- DATA_WIDTH, 32, instruction word width and memory write-address width (the PC is a byte address of this width).
- WORD_COUNT, 256, maximum number of words per load; exceeding it is an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_last  input  1  qualifies byte_in as the final byte of the program.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  DATA_WIDTH  byte address of the write, always a multiple of 4.
- mem_wd  output  DATA_WIDTH  write data word.
- cpu_rst  output  1  reset to the CPU core, active-high.
- busy  output  1  load in progress.
- done  output  1  load completed successfully.
- error  output  1  word-count overflow.
- words_loaded  output  $clog2(WORD_COUNT)+1  number of words written in the current load.

Behaviour:
- Reset is asynchronous and applies immediately:
  - state=IDLE.
  - cpu_rst=1; byte_ready, mem_we, busy, done, error = 0.
  - mem_addr, mem_wd, words_loaded = 0.
  - Byte lane index cleared.
- A byte is accepted only when byte_valid && byte_ready at a rising clk edge.
- IDLE:
  - cpu_rst=1, byte_ready=0.
  - start -> RECV; clear lane index, word buffer, mem_addr and words_loaded.
- RECV:
  - byte_ready=1, busy=1.
  - An accepted byte goes into lane k, bits [8k+7:8k], and k increments.
  - Move to WRITE after the lane-3 byte is accepted, or after any accepted byte with byte_last=1.
  - On an early byte_last, unfilled upper lanes are zero.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_wd=assembled word, mem_addr=current byte address.
  - On exit: mem_addr += 4, words_loaded += 1, lane index and buffer cleared.
  - Next state:
    - If last was seen -> DONE.
    - Else if words_loaded (after increment) == WORD_COUNT -> ERR.
    - Else -> RECV.
- Throughput: 4 bytes per 5 cycles at best. mem_we is registered: it is asserted in the cycle following acceptance of the final byte of the word.
- DONE:
  - cpu_rst=0, done=1, busy=0, byte_ready=0.
  - words_loaded and mem_addr (next free address) are held.
  - start -> RECV, with cpu_rst=1 and done=0 from the next cycle.
- ERR:
  - error=1, cpu_rst=1, byte_ready=0, busy=0.
  - start -> RECV with error cleared.
- start is ignored in RECV and WRITE.
- byte_last in a byte that is not valid is ignored.
- Only WRITE asserts mem_we.
- cpu_rst deasserts only in DONE.
- Reset mid-load abandons the partial word with no write issued. Words already written are not scrubbed.
- Address wrap does not occur, because WORD_COUNT*4 must fit in DATA_WIDTH.

Test Plan:
1. Reset, start, bytes 93 00 10 00 (last on the 4th) -> one mem_we pulse: addr 0x0, wd 0x00100093. Then done=1, cpu_rst=0, words_loaded=1.
2. 8 bytes with byte_valid gaps of 0-3 cycles -> writes at 0x0 then 0x4 with the correct words. byte_ready=0 in each WRITE cycle, and no byte is dropped or duplicated.
3. 6 bytes AA BB CC DD 11 22, last on the 6th -> writes 0xDDCCBBAA @0x0 and 0x00002211 @0x4. words_loaded=2.
4. WORD_COUNT=2, 12 bytes with no last -> two writes, then error=1, cpu_rst=1, byte_ready=0. A later start -> busy=1, error=0, mem_addr=0.
5. rst asserted asynchronously after 2 accepted bytes -> all outputs take reset values before the next edge, with no mem_we. A new start loads from address 0.
6. start pulsed during RECV -> no effect. start in DONE -> cpu_rst=1 and done=0 next cycle, words_loaded=0, reload overwrites from 0x0.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs bytes little-endian into words, writes them
// to instruction memory from address 0, and holds the CPU in reset until a clean finish.
module instr_loader #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WORD_COUNT    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    input  logic                          byte_last,
    output logic                          byte_ready,
    output logic                          mem_we,
    output logic [DATA_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wd,
    output logic                          cpu_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(WORD_COUNT):0]   words_loaded
);

    localparam int unsigned CNT_W = $clog2(WORD_COUNT) + 1;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               lane;
    logic [DATA_WIDTH-1:0]    word_buf;
    logic [DATA_WIDTH-1:0]    word_c;
    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     last_seen;
    logic                     accept;
    logic                     final_byte;
    logic                     cpu_rst_d, byte_ready_d, mem_we_d, busy_d, done_d, error_d;

    assign accept     = byte_valid && byte_ready;
    assign final_byte = (lane == 2'd3) || byte_last;
    assign mem_addr   = DATA_WIDTH'({word_idx, 2'b00});

    // Incoming byte merged into its lane of the word under assembly.
    always_comb begin
        word_c = word_buf;
        word_c[{lane, 3'b000} +: 8] = byte_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RECV;
            RECV:  if (accept && final_byte) state_nxt = WRITE;
            WRITE: begin
                if (last_seen)                                        state_nxt = DONE;
                else if (words_loaded + CNT_W'(1) == CNT_W'(WORD_COUNT)) state_nxt = ERR;
                else                                                  state_nxt = RECV;
            end
            DONE:  if (start) state_nxt = RECV;
            ERR:   if (start) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they register in step with it.
    always_comb begin
        cpu_rst_d    = 1'b1;
        byte_ready_d = 1'b0;
        mem_we_d     = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        case (state_nxt)
            RECV:  begin byte_ready_d = 1'b1; busy_d = 1'b1; end
            WRITE: begin mem_we_d = 1'b1; busy_d = 1'b1; end
            DONE:  begin cpu_rst_d = 1'b0; done_d = 1'b1; end
            ERR:   error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rst    <= 1'b1;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            cpu_rst    <= cpu_rst_d;
            byte_ready <= byte_ready_d;
            mem_we     <= mem_we_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    // Word assembly, write data capture and load counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane         <= 2'd0;
            word_buf     <= '0;
            last_seen    <= 1'b0;
            mem_wd       <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (accept) begin
                        word_buf <= word_c;
                        lane     <= lane + 2'd1;
                        if (byte_last)  last_seen <= 1'b1;
                        if (final_byte) mem_wd    <= word_c;
                    end
                end
                WRITE: begin
                    lane         <= 2'd0;
                    word_buf     <= '0;
                    word_idx     <= word_idx + ADDRESS_WIDTH'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                end
                default: begin
                    if (start) begin
                        lane         <= 2'd0;
                        word_buf     <= '0;
                        last_seen    <= 1'b0;
                        word_idx     <= '0;
                        words_loaded <= '0;
                    end
                end
            endcase
        end
    end

endmodule
